// File: rtl/ir_loader_pkg.sv
// Shared definitions for the instruction-register loader: FSM encodings,
// default bus widths and a small sizing helper.
package ir_loader_pkg;

  localparam int IR_DATA_WIDTH = 8;
  localparam int IR_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_REQ   = 3'd1,
    L_WAIT  = 3'd2,
    L_WRITE = 3'd3,
    L_DONE  = 3'd4,
    L_ERR   = 3'd5
  } ldr_state_e;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ir_loader_timer.sv
// Loadable down-counter that flags expiry once it reaches zero; bounds the
// number of cycles the loader waits for a memory response.
module ir_loader_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ir_loader.sv
// Fetches DEPTH instruction words from the memory source one request at a
// time and writes them into the IR regfile, then flags init finished.
//
// state   | meaning
// --------+-----------------------------------------------------------
// L_IDLE  | out of reset, waiting for i_start
// L_REQ   | single-cycle memory read request for word idx
// L_WAIT  | waiting for i_mem_valid, bounded by the timeout timer
// L_WRITE | single-cycle regfile write of data_q at idx
// L_DONE  | all words written, init finished held; i_start reloads
// L_ERR   | memory timed out, error held; i_start retries from word 0
module ir_loader
  import ir_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = IR_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = IR_ADDR_WIDTH,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_rf_we,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  output logic [DATA_WIDTH-1:0] o_rf_data,
  output logic                  o_busy,
  output logic                  o_init_finished,
  output logic                  o_error
);

  localparam int IDX_W = min1_clog2(DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  ldr_state_e            state, state_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] data_q, data_next;
  logic                  tmr_load, tmr_en, tmr_expired;
  logic                  req_d, we_d, busy_d, init_d, err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  ir_loader_timer #(.WIDTH(TMO_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TMO_LOAD),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= L_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    data_next  = data_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      L_IDLE, L_DONE, L_ERR: begin
        if (i_start) begin
          state_next = L_REQ;
          idx_next   = '0;
        end
      end
      L_REQ: begin
        state_next = L_WAIT;
        tmr_load   = 1'b1;
      end
      L_WAIT: begin
        // A response on the terminal cycle still counts.
        if (i_mem_valid) begin
          state_next = L_WRITE;
          data_next  = i_mem_data;
        end else if (tmr_expired) begin
          state_next = L_ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      L_WRITE: begin
        if (idx == LAST_IDX) begin
          state_next = L_DONE;
        end else begin
          state_next = L_REQ;
          idx_next   = idx + 1'b1;
        end
      end
      default: state_next = L_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    req_d      = (state_next == L_REQ);
    we_d       = (state_next == L_WRITE);
    busy_d     = (state_next == L_REQ) || (state_next == L_WAIT) || (state_next == L_WRITE);
    init_d     = (state_next == L_DONE);
    err_d      = (state_next == L_ERR);
    mem_addr_d = '0;
    if (req_d) begin
      mem_addr_d = BASE_ADDR + ADDR_WIDTH'(idx_next);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx             <= '0;
      data_q          <= '0;
      o_mem_req       <= 1'b0;
      o_mem_addr      <= '0;
      o_rf_we         <= 1'b0;
      o_busy          <= 1'b0;
      o_init_finished <= 1'b0;
      o_error         <= 1'b0;
    end else begin
      idx             <= idx_next;
      data_q          <= data_next;
      o_mem_req       <= req_d;
      o_mem_addr      <= mem_addr_d;
      o_rf_we         <= we_d;
      o_busy          <= busy_d;
      o_init_finished <= init_d;
      o_error         <= err_d;
    end
  end

  assign o_rf_addr = ADDR_WIDTH'(idx);
  assign o_rf_data = data_q;

endmodule

// File: tb/tb_ir_loader.sv
// Directed bench for ir_loader (DEPTH=4, BASE_ADDR=8'h10, TIMEOUT=8): the
// initial block plays the memory source and records every request and write.
module tb_ir_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic       o_mem_req;
  logic [7:0] o_mem_addr;
  logic       i_mem_valid;
  logic [7:0] i_mem_data;
  logic       o_rf_we;
  logic [7:0] o_rf_addr;
  logic [7:0] o_rf_data;
  logic       o_busy;
  logic       o_init_finished;
  logic       o_error;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [7:0] rq_a[$];

  always #5 clk = ~clk;

  ir_loader #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .DEPTH      (4),
    .BASE_ADDR  (8'h10),
    .TIMEOUT    (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .o_mem_req       (o_mem_req),
    .o_mem_addr      (o_mem_addr),
    .i_mem_valid     (i_mem_valid),
    .i_mem_data      (i_mem_data),
    .o_rf_we         (o_rf_we),
    .o_rf_addr       (o_rf_addr),
    .o_rf_data       (o_rf_data),
    .o_busy          (o_busy),
    .o_init_finished (o_init_finished),
    .o_error         (o_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Pulses i_start, then answers each request after
  // 'lat' cycles (word 'drop' never answered). Cycle 0 is the first REQ cycle.
  task automatic load(input int lat, input int drop, input bit spur, input int budget,
                      output int done_c, output int err_c, output bit init_at_req);
    int cnt;
    int nreq;
    cnt = -1;
    nreq = 0;
    done_c = -1;
    err_c = -1;
    init_at_req = 1'b1;
    wr_a.delete();
    wr_d.delete();
    rq_a.delete();
    i_start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < budget; c++) begin
      i_start = 1'b0;
      i_mem_valid = 1'b0;
      i_mem_data = 8'h00;
      if (c == 0) init_at_req = o_init_finished;
      if (o_rf_we) begin
        wr_a.push_back(o_rf_addr);
        wr_d.push_back(o_rf_data);
      end
      if (o_init_finished) begin
        done_c = c;
        break;
      end
      if (o_error) begin
        err_c = c;
        break;
      end
      if (o_mem_req) begin
        rq_a.push_back(o_mem_addr);
        cnt = (nreq == drop) ? -1 : lat;
        nreq++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          i_mem_valid = 1'b1;
          i_mem_data = 8'hA0 + 8'(nreq - 1);
          cnt = -1;
        end
      end
      if (spur && !i_mem_valid) begin
        i_start = 1'b1;
        if (o_mem_req || o_rf_we) begin
          i_mem_valid = 1'b1;
          i_mem_data = 8'hEE;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic check_log(input string tag, input int n_wr, input int n_rq);
    chk({tag, "_nwr"}, 32'(wr_a.size()), 32'(n_wr));
    chk({tag, "_nrq"}, 32'(rq_a.size()), 32'(n_rq));
    for (int i = 0; i < n_wr && i < wr_a.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), 32'(wr_a[i]), 32'(i));
      chk($sformatf("%s_wd%0d", tag, i), 32'(wr_d[i]), 32'(8'hA0 + i));
    end
    for (int i = 0; i < n_rq && i < rq_a.size(); i++) begin
      chk($sformatf("%s_ra%0d", tag, i), 32'(rq_a[i]), 32'(8'h10 + i));
    end
  endtask

  initial begin
    int dc, ec;
    bit iar;
    int extra_we;

    rst_n = 1'b0;
    i_start = 1'b0;
    i_mem_valid = 1'b0;
    i_mem_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outs", {o_mem_req, o_mem_addr, o_rf_we, o_rf_addr, o_rf_data,
                       o_busy, o_init_finished, o_error}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", o_busy, 1'b0);

    // 1: nominal, one-cycle memory
    load(1, -1, 1'b0, 200, dc, ec, iar);
    chk("nom_done_cycle", dc, 12);
    chk("nom_err", o_error, 1'b0);
    chk("nom_busy", o_busy, 1'b0);
    check_log("nom", 4, 4);

    // 2: slow memory, valid on the 5th wait cycle
    load(5, -1, 1'b0, 200, dc, ec, iar);
    chk("slow_done_cycle", dc, 28);
    chk("slow_err", o_error, 1'b0);
    check_log("slow", 4, 4);

    // valid on the terminal wait cycle beats the timeout
    load(8, -1, 1'b0, 200, dc, ec, iar);
    chk("edge8_done_cycle", dc, 40);
    chk("edge8_err", o_error, 1'b0);
    check_log("edge8", 4, 4);

    // one cycle later is too late
    load(9, -1, 1'b0, 200, dc, ec, iar);
    chk("edge9_err_cycle", ec, 9);
    chk("edge9_init", o_init_finished, 1'b0);
    check_log("edge9", 0, 1);

    // 3: timeout on word 2, then retry with good memory
    load(1, 2, 1'b0, 200, dc, ec, iar);
    chk("tmo_err_cycle", ec, 15);
    chk("tmo_init", o_init_finished, 1'b0);
    chk("tmo_busy", o_busy, 1'b0);
    check_log("tmo", 2, 3);
    extra_we = 0;
    for (int k = 0; k < 3; k++) begin
      i_mem_valid = 1'b1;
      @(negedge clk);
      if (o_rf_we) extra_we++;
    end
    i_mem_valid = 1'b0;
    chk("tmo_err_held", o_error, 1'b1);
    chk("tmo_no_we", extra_we, 0);
    load(1, -1, 1'b0, 200, dc, ec, iar);
    chk("retry_done_cycle", dc, 12);
    chk("retry_err_clear", o_error, 1'b0);
    check_log("retry", 4, 4);

    // 4: spurious valid / start in DONE, REQ, WRITE and mid-load
    extra_we = 0;
    for (int k = 0; k < 3; k++) begin
      i_mem_valid = 1'b1;
      i_mem_data = 8'h55;
      @(negedge clk);
      if (o_rf_we || o_busy) extra_we++;
    end
    i_mem_valid = 1'b0;
    chk("spur_idle_quiet", extra_we, 0);
    load(1, -1, 1'b1, 200, dc, ec, iar);
    chk("spur_done_cycle", dc, 12);
    check_log("spur", 4, 4);

    // 5: reset during the wait for word 1
    load(1, -1, 1'b0, 4, dc, ec, iar);
    chk("rstmid_in_wait", {o_busy, o_mem_req, o_rf_we}, 3'b100);
    chk("rstmid_partial_wr", 32'(wr_a.size()), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_outs", {o_mem_req, o_mem_addr, o_rf_we, o_rf_addr, o_rf_data,
                        o_busy, o_init_finished, o_error}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    load(1, -1, 1'b0, 200, dc, ec, iar);
    chk("rstmid_reload_done", dc, 12);
    check_log("rstmid", 4, 4);

    // 6: reload from DONE
    chk("reload_pre_init", o_init_finished, 1'b1);
    load(1, -1, 1'b0, 200, dc, ec, iar);
    chk("reload_init_drop", iar, 1'b0);
    chk("reload_done_cycle", dc, 12);
    chk("reload_init_set", o_init_finished, 1'b1);
    check_log("reload", 4, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
